// File: rtl/temp_sample_scheduler.sv
// temp_sample_scheduler
//   Sequences a DS18B20 conversion/read engine. It issues periodic start
//   requests and supervises each transaction with a timeout and bounded
//   retries. Sign/magnitude readings are converted to two's complement and
//   averaged over 2^AVG_LOG2 samples. The averages drive hysteretic high and
//   low alarms.
//
// Ports
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   enable               run; low returns to IDLE and drops the partial window
//   clear_err            pulse; leaves ERROR and clears err_flag
//   start_req            one-cycle engine start pulse
//   eng_busy/done/fail   engine handshake (done/fail are one-cycle pulses)
//   temp_mag/temp_neg    sign/magnitude reading, 0.01 degC
//   hi_thresh/lo_thresh  signed alarm thresholds, 0.01 degC
//   temp_avg/avg_valid   signed average and its update pulse
//   alarm_hi/alarm_lo    hysteretic alarms
//   err_flag             sticky error (retries exhausted)
module temp_sample_scheduler #(
  parameter int CLKS_PER_MS = 50000,
  parameter int PERIOD_MS   = 1000,
  parameter int TIMEOUT_MS  = 1000,
  parameter int MAX_RETRY   = 3,
  parameter int AVG_LOG2    = 2,
  parameter int HYST        = 100
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  input  logic        clear_err,
  output logic        start_req,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic        eng_fail,
  input  logic [13:0] temp_mag,
  input  logic        temp_neg,
  input  logic [14:0] hi_thresh,
  input  logic [14:0] lo_thresh,
  output logic [14:0] temp_avg,
  output logic        avg_valid,
  output logic        alarm_hi,
  output logic        alarm_lo,
  output logic        err_flag
);

  localparam int PW    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int MSMAX = (PERIOD_MS > TIMEOUT_MS) ? PERIOD_MS : TIMEOUT_MS;
  localparam int MW    = (MSMAX > 1) ? $clog2(MSMAX + 1) : 1;
  localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int AW    = 15 + AVG_LOG2;
  localparam int NW    = AVG_LOG2 + 1;

  typedef enum logic [2:0] {
    IDLE, START, WAIT_DONE, ACCUM, OUTPUT, WAIT_PERIOD, ERROR
  } state_t;

  state_t                state;
  logic [PW-1:0]         pre;
  logic [MW-1:0]         ms_cnt;
  logic [RW-1:0]         retry_cnt;
  logic [NW-1:0]         n;
  logic signed [AW-1:0]  acc;
  logic signed [14:0]    value;

  logic                  tick;
  logic                  timeout;
  logic                  period_end;
  logic                  win_full;
  logic signed [14:0]    mag_s;
  logic signed [14:0]    rd_val;
  logic signed [AW-1:0]  acc_sum;
  logic signed [AW-1:0]  acc_shr;
  logic signed [14:0]    avg_new;
  logic signed [15:0]    avg_w;
  logic signed [15:0]    hi_w;
  logic signed [15:0]    lo_w;
  logic signed [15:0]    hi_clr;
  logic signed [15:0]    lo_clr;

  assign tick       = (pre == PW'(CLKS_PER_MS - 1));
  assign timeout    = tick && (ms_cnt == MW'(TIMEOUT_MS - 1));
  assign period_end = tick && (ms_cnt == MW'(PERIOD_MS - 1));
  // n still holds the pre-increment count while in ACCUM
  assign win_full   = (n == NW'((1 << AVG_LOG2) - 1));

  assign mag_s   = $signed({1'b0, temp_mag});
  assign rd_val  = temp_neg ? -mag_s : mag_s;

  // Average and alarm decisions are formed from the post-accumulate sum so the
  // registered results are already visible during the OUTPUT cycle.
  assign acc_sum = acc + AW'(value);
  assign acc_shr = acc_sum >>> AVG_LOG2;
  assign avg_new = acc_shr[14:0];
  assign avg_w   = 16'(avg_new);
  assign hi_w    = 16'($signed(hi_thresh));
  assign lo_w    = 16'($signed(lo_thresh));
  assign hi_clr  = hi_w - 16'(HYST);
  assign lo_clr  = lo_w + 16'(HYST);

  // Single FSM process. Every state change clears the ms prescaler and the
  // ms counter, so a wait of N ms is exactly N*CLKS_PER_MS cycles.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      pre       <= '0;
      ms_cnt    <= '0;
      retry_cnt <= '0;
      n         <= '0;
      acc       <= '0;
      value     <= '0;
      start_req <= 1'b0;
      avg_valid <= 1'b0;
      temp_avg  <= '0;
      alarm_hi  <= 1'b0;
      alarm_lo  <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      start_req <= 1'b0;
      avg_valid <= 1'b0;
      if (tick) begin
        pre    <= '0;
        ms_cnt <= ms_cnt + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end

      if (!enable) begin
        // Outputs (temp_avg, alarms, err_flag) deliberately hold.
        state     <= IDLE;
        acc       <= '0;
        n         <= '0;
        retry_cnt <= '0;
        pre       <= '0;
        ms_cnt    <= '0;
      end else begin
        if (clear_err && state != ERROR) err_flag <= 1'b0;
        case (state)
          IDLE: begin
            state  <= START;
            pre    <= '0;
            ms_cnt <= '0;
          end
          START: begin
            if (!eng_busy) begin
              start_req <= 1'b1;
              state     <= WAIT_DONE;
              pre       <= '0;
              ms_cnt    <= '0;
            end
          end
          WAIT_DONE: begin
            // A fail wins over a simultaneous done; done wins over timeout.
            if (eng_fail || (!eng_done && timeout)) begin
              pre    <= '0;
              ms_cnt <= '0;
              if (retry_cnt < RW'(MAX_RETRY)) begin
                retry_cnt <= retry_cnt + 1'b1;
                state     <= START;
              end else begin
                err_flag <= 1'b1;
                state    <= ERROR;
              end
            end else if (eng_done) begin
              value  <= rd_val;
              state  <= ACCUM;
              pre    <= '0;
              ms_cnt <= '0;
            end
          end
          ACCUM: begin
            acc       <= acc_sum;
            n         <= n + 1'b1;
            retry_cnt <= '0;
            pre       <= '0;
            ms_cnt    <= '0;
            if (win_full) begin
              temp_avg  <= avg_new;
              avg_valid <= 1'b1;
              if (avg_w > hi_w)        alarm_hi <= 1'b1;
              else if (avg_w < hi_clr) alarm_hi <= 1'b0;
              if (avg_w < lo_w)        alarm_lo <= 1'b1;
              else if (avg_w > lo_clr) alarm_lo <= 1'b0;
              state <= OUTPUT;
            end else begin
              state <= WAIT_PERIOD;
            end
          end
          OUTPUT: begin
            acc    <= '0;
            n      <= '0;
            state  <= WAIT_PERIOD;
            pre    <= '0;
            ms_cnt <= '0;
          end
          WAIT_PERIOD: begin
            if (period_end) begin
              state  <= START;
              pre    <= '0;
              ms_cnt <= '0;
            end
          end
          ERROR: begin
            err_flag <= 1'b1;
            if (clear_err) begin
              err_flag  <= 1'b0;
              retry_cnt <= '0;
              acc       <= '0;
              n         <= '0;
              state     <= START;
              pre       <= '0;
              ms_cnt    <= '0;
            end
          end
          default: begin
            state  <= IDLE;
            pre    <= '0;
            ms_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
